// File: rtl/hc595_display_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_display_rx_if
//  Description : 74HC595 display link wires plus decoded receive-side results
//  Revision    : 1.0  initial release
// ============================================================================
interface hc595_display_rx_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    sclk;
    logic                    rclk;
    logic                    dio;
    logic [7:0]              seg_byte;
    logic [7:0]              dig_byte;
    logic                    frame_valid;
    logic                    frame_err;
    logic [4*NUM_DIGITS-1:0] number;
    logic                    number_valid;

    // Master drives the link (display driver or bench); slave is the receiver.
    modport master (
        output sclk, rclk, dio,
        input  seg_byte, dig_byte, frame_valid, frame_err, number, number_valid
    );

    modport slave (
        input  sclk, rclk, dio,
        output seg_byte, dig_byte, frame_valid, frame_err, number, number_valid
    );
endinterface
`default_nettype wire

// File: rtl/hc595_display_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_display_rx
//  Description : Oversampling receiver for the 74HC595 7-segment display link;
//                decodes each latched frame and publishes the shown number.
//  Revision    : 1.0  initial release
// ============================================================================
module hc595_display_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    hc595_display_rx_if.slave   link
);

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_rclk_sync;
    logic [SYNC_STAGES-1:0]  r_dio_sync;
    logic                    r_sclk_prev;
    logic                    r_rclk_prev;
    logic                    r_sclk_rise;
    logic                    r_rclk_rise;
    logic                    r_dio_bit;

    logic [15:0]             r_sr;
    logic [4:0]              r_bit_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [4*NUM_DIGITS-1:0] r_number;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [7:0]              r_seg_byte;
    logic [7:0]              r_dig_byte;
    logic                    r_frame_valid;
    logic                    r_frame_err;
    logic                    r_number_valid;

    logic [4:0]              w_dec;
    logic [7:0]              w_dig;
    logic [2:0]              w_sel_idx;
    logic                    w_sel_ok;
    logic                    w_count_ok;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_accept_mask;
    logic                    w_seen_full;

    // Returns {known, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = 5'h10;
            7'h06:   res = 5'h11;
            7'h5B:   res = 5'h12;
            7'h4F:   res = 5'h13;
            7'h66:   res = 5'h14;
            7'h6D:   res = 5'h15;
            7'h7D:   res = 5'h16;
            7'h07:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h6F:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h7C:   res = 5'h1B;
            7'h39:   res = 5'h1C;
            7'h5E:   res = 5'h1D;
            7'h79:   res = 5'h1E;
            7'h71:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // The extra rise/data register stage makes the frame decision land
    // SYNC_STAGES+1 cycles after rclk is first sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_rclk_sync <= '0;
            r_dio_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_rclk_prev <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_rclk_rise <= 1'b0;
            r_dio_bit   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], link.sclk};
            r_rclk_sync <= {r_rclk_sync[SYNC_STAGES-2:0], link.rclk};
            r_dio_sync  <= {r_dio_sync[SYNC_STAGES-2:0],  link.dio};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_rclk_prev <= r_rclk_sync[SYNC_STAGES-1];
            r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
            r_rclk_rise <= r_rclk_sync[SYNC_STAGES-1] & ~r_rclk_prev;
            r_dio_bit   <= r_dio_sync[SYNC_STAGES-1];
        end
    end

    assign w_dec      = decode_seg(~r_sr[14:8]);
    assign w_dig      = r_sr[7:0];
    assign w_count_ok = (r_bit_cnt == 5'(FRAME_BITS));

    always_comb begin
        w_sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_dig[i]) w_sel_idx = 3'(i);
        end
    end

    assign w_sel_ok = (w_dig != 8'd0) && ((w_dig & (w_dig - 8'd1)) == 8'd0)
                      && (int'(w_sel_idx) < NUM_DIGITS);
    assign w_accept = r_rclk_rise & w_count_ok & w_sel_ok & w_dec[4];

    always_comb begin
        w_accept_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_accept && (int'(w_sel_idx) == i)) w_accept_mask[i] = 1'b1;
        end
    end

    assign w_seen_full = &r_seen;

    // Frame evaluation uses r_sr/r_bit_cnt before any coincident shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr           <= '0;
            r_bit_cnt      <= '0;
            r_digits       <= '0;
            r_number       <= '0;
            r_seen         <= '0;
            r_seg_byte     <= '0;
            r_dig_byte     <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_err    <= 1'b0;
            r_number_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_accept;
            r_frame_err   <= r_rclk_rise & ~w_accept;

            if (r_sclk_rise) r_sr <= {r_sr[14:0], r_dio_bit};

            if (r_rclk_rise)
                r_bit_cnt <= r_sclk_rise ? 5'd1 : 5'd0;
            else if (r_sclk_rise && (r_bit_cnt != 5'd31))
                r_bit_cnt <= r_bit_cnt + 5'd1;

            if (w_accept) begin
                r_seg_byte <= r_sr[15:8];
                r_dig_byte <= r_sr[7:0];
            end

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept_mask[i]) r_digits[4*i +: 4] <= w_dec[3:0];
            end

            r_seen         <= (w_seen_full ? '0 : r_seen) | w_accept_mask;
            r_number_valid <= w_seen_full;
            if (w_seen_full) r_number <= r_digits;
        end
    end

    assign link.seg_byte     = r_seg_byte;
    assign link.dig_byte     = r_dig_byte;
    assign link.frame_valid  = r_frame_valid;
    assign link.frame_err    = r_frame_err;
    assign link.number       = r_number;
    assign link.number_valid = r_number_valid;

endmodule
`default_nettype wire

// File: tb/tb_hc595_display_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc595_display_rx
//  Description : Directed bench for hc595_display_rx with pulse counting.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hc595_display_rx;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fv_cnt, fe_cnt, nv_cnt, both_cnt, long_cnt;
    logic prev_fv, prev_fe, prev_nv;

    hc595_display_rx_if #(.NUM_DIGITS(4)) link ();

    hc595_display_rx #(
        .FRAME_BITS  (16),
        .NUM_DIGITS  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (link.frame_valid === 1'b1) fv_cnt++;
        if (link.frame_err === 1'b1) fe_cnt++;
        if (link.number_valid === 1'b1) nv_cnt++;
        if (link.frame_valid === 1'b1 && link.frame_err === 1'b1) both_cnt++;
        if ((link.frame_valid === 1'b1 && prev_fv) || (link.frame_err === 1'b1 && prev_fe)
            || (link.number_valid === 1'b1 && prev_nv)) long_cnt++;
        prev_fv = (link.frame_valid === 1'b1);
        prev_fe = (link.frame_err === 1'b1);
        prev_nv = (link.number_valid === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends w[n-1] down to w[0], MSB first.
    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            link.dio = w[i];
            idle(6);
            link.sclk = 1'b1;
            idle(6);
            link.sclk = 1'b0;
        end
        idle(6);
    endtask

    task automatic latch();
        link.rclk = 1'b1;
        idle(6);
        link.rclk = 1'b0;
        idle(6);
    endtask

    task automatic send_frame(input logic [7:0] seg, input logic [7:0] dig);
        shift_bits({seg, dig}, 16);
        latch();
    endtask

    task automatic send_1239();
        send_frame(8'h90, 8'h01);
        send_frame(8'hB0, 8'h02);
        send_frame(8'hA4, 8'h04);
        send_frame(8'hF9, 8'h08);
        idle(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (link.seg_byte !== 8'h00 || link.dig_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_bytes: got seg=%h dig=%h, required 00/00", link.seg_byte, link.dig_byte);
        end
        checks++;
        if (link.number !== 16'h0000) begin
            failures++;
            $display("FAIL reset_number: got %h, required 0000", link.number);
        end
        checks++;
        if (fv_cnt + fe_cnt + nv_cnt != 0) begin
            failures++;
            $display("FAIL reset_pulses: got %0d pulses, required 0", fv_cnt + fe_cnt + nv_cnt);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_latency();
        shift_bits({8'hC0, 8'h01}, 16);
        @(negedge clk);
        link.rclk = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (link.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got frame_valid=%b, required 0", link.frame_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (link.frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_on_time: got frame_valid=%b, required 1", link.frame_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (link.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_width: got frame_valid=%b, required 0", link.frame_valid);
        end
        idle(6);
        link.rclk = 1'b0;
        idle(6);
    endtask

    task automatic test_four_frames();
        int fv0 = fv_cnt, fe0 = fe_cnt, nv0 = nv_cnt;
        send_1239();
        checks++;
        if (fv_cnt - fv0 != 4 || fe_cnt != fe0) begin
            failures++;
            $display("FAIL four_frames_pulses: got valid=%0d err=%0d, required 4/0", fv_cnt - fv0, fe_cnt - fe0);
        end
        checks++;
        if (nv_cnt - nv0 != 1 || link.number !== 16'h1239) begin
            failures++;
            $display("FAIL four_frames_number: got %h (nv=%0d), required 1239 (nv=1)", link.number, nv_cnt - nv0);
        end
        checks++;
        if (link.seg_byte !== 8'hF9 || link.dig_byte !== 8'h08) begin
            failures++;
            $display("FAIL four_frames_bytes: got %h/%h, required F9/08", link.seg_byte, link.dig_byte);
        end
    endtask

    task automatic test_bad_count();
        int fv0 = fv_cnt, fe0 = fe_cnt;
        shift_bits({8'hC0, 8'h01}, 15);
        latch();
        checks++;
        if (fe_cnt - fe0 != 1 || fv_cnt != fv0) begin
            failures++;
            $display("FAIL short_frame: got err=%0d valid=%0d, required 1/0", fe_cnt - fe0, fv_cnt - fv0);
        end
        checks++;
        if (link.number !== 16'h1239 || link.seg_byte !== 8'hF9) begin
            failures++;
            $display("FAIL short_frame_hold: got %h/%h, required 1239/F9", link.number, link.seg_byte);
        end
        shift_bits(16'h0000, 1);
        shift_bits({8'hC0, 8'h01}, 16);
        latch();
        checks++;
        if (fe_cnt - fe0 != 2 || fv_cnt != fv0) begin
            failures++;
            $display("FAIL long_frame: got err=%0d valid=%0d, required 2/0", fe_cnt - fe0, fv_cnt - fv0);
        end
    endtask

    task automatic test_bad_select();
        int fe0, nv0;
        send_frame(8'h99, 8'h01);
        send_frame(8'h92, 8'h02);
        send_frame(8'h82, 8'h04);
        fe0 = fe_cnt;
        nv0 = nv_cnt;
        send_frame(8'h90, 8'h03);
        send_frame(8'h90, 8'h10);
        send_frame(8'hFF, 8'h01);
        send_frame(8'hFE, 8'h02);
        idle(4);
        checks++;
        if (fe_cnt - fe0 != 4 || nv_cnt != nv0) begin
            failures++;
            $display("FAIL bad_select: got err=%0d nv=%0d, required 4/0", fe_cnt - fe0, nv_cnt - nv0);
        end
        checks++;
        if (link.seg_byte !== 8'h82 || link.dig_byte !== 8'h04) begin
            failures++;
            $display("FAIL bad_select_bytes: got %h/%h, required 82/04", link.seg_byte, link.dig_byte);
        end
        send_frame(8'h78, 8'h08);
        idle(4);
        checks++;
        if (nv_cnt - nv0 != 1 || link.number !== 16'h7654) begin
            failures++;
            $display("FAIL seen_kept: got %h (nv=%0d), required 7654 (nv=1)", link.number, nv_cnt - nv0);
        end
    endtask

    task automatic test_coincident();
        int fv0 = fv_cnt, fe0 = fe_cnt;
        shift_bits({8'h88, 8'h01}, 16);
        link.dio = 1'b1;
        idle(6);
        link.sclk = 1'b1;
        link.rclk = 1'b1;
        idle(6);
        link.sclk = 1'b0;
        link.rclk = 1'b0;
        idle(6);
        checks++;
        if (fv_cnt - fv0 != 1 || fe_cnt != fe0) begin
            failures++;
            $display("FAIL coincident_accept: got valid=%0d err=%0d, required 1/0", fv_cnt - fv0, fe_cnt - fe0);
        end
        shift_bits({8'h83, 8'h02}, 15);
        latch();
        checks++;
        if (fv_cnt - fv0 != 2 || fe_cnt != fe0) begin
            failures++;
            $display("FAIL coincident_carry: got valid=%0d err=%0d, required 2/0", fv_cnt - fv0, fe_cnt - fe0);
        end
        send_frame(8'hC6, 8'h04);
        send_frame(8'hA1, 8'h08);
        idle(4);
        checks++;
        if (link.number !== 16'hDCBA) begin
            failures++;
            $display("FAIL coincident_number: got %h, required DCBA", link.number);
        end
    endtask

    task automatic test_reset_mid();
        int nv0;
        send_frame(8'h90, 8'h01);
        shift_bits({8'hB0, 8'h02}, 8);
        rst = 1'b1;
        idle(2);
        checks++;
        if (link.number !== 16'h0000 || link.seg_byte !== 8'h00 || link.dig_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: got %h %h/%h, required 0000 00/00", link.number, link.seg_byte, link.dig_byte);
        end
        rst = 1'b0;
        idle(4);
        nv0 = nv_cnt;
        send_1239();
        checks++;
        if (nv_cnt - nv0 != 1 || link.number !== 16'h1239) begin
            failures++;
            $display("FAIL reset_mid_recover: got %h (nv=%0d), required 1239 (nv=1)", link.number, nv_cnt - nv0);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (both_cnt != 0 || long_cnt != 0) begin
            failures++;
            $display("FAIL pulse_rules: got overlap=%0d long=%0d, required 0/0", both_cnt, long_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        fv_cnt    = 0;
        fe_cnt    = 0;
        nv_cnt    = 0;
        both_cnt  = 0;
        long_cnt  = 0;
        prev_fv   = 1'b0;
        prev_fe   = 1'b0;
        prev_nv   = 1'b0;
        rst       = 1'b1;
        link.sclk = 1'b0;
        link.rclk = 1'b0;
        link.dio  = 1'b0;
        test_reset();
        test_latency();
        test_four_frames();
        test_bad_count();
        test_bad_select();
        test_coincident();
        test_reset_mid();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
